// File: rtl/tape_pkg.sv
// Shared tape definitions: cell symbol encodings and the tape writer state set.
// Used by unary_tape_writer (producer) and the turing consumer.
package tape_pkg;

  localparam logic [1:0] SYMB_A     = 2'b00;
  localparam logic [1:0] SYMB_ADD   = 2'b01;
  localparam logic [1:0] SYMB_BLANK = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StRunA,
    StSep,
    StRunB,
    StTerm,
    StClear,
    StFin
  } writer_state_e;

endpackage

// File: rtl/unary_tape_writer_if.sv
// Request/tape-write bundle between the tape writer (master) and its environment (slave).
interface unary_tape_writer_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned OPW    = 5
);
  logic              start;
  logic [OPW-1:0]    op_a;
  logic [OPW-1:0]    op_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        wr_symb;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, op_a, op_b,
    output wr_en, wr_addr, wr_symb, busy, done, err
  );

  modport slave (
    output start, op_a, op_b,
    input  wr_en, wr_addr, wr_symb, busy, done, err
  );
endinterface

// File: rtl/unary_tape_writer_emit.sv
// unary_run_emit: down-counter for a run of consecutive writes plus the shared,
// monotonically incrementing tape address.
module unary_run_emit #(
  parameter int unsigned CNT_W  = 7,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [CNT_W-1:0]  load_val,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    cnt_d  = cnt_q;
    addr_d = addr_q;
    // A load wins over the decrement; the address still advances on that write.
    if (load) begin
      cnt_d = load_val;
    end else if (step) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (clr) begin
      addr_d = '0;
    end else if (step) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      addr_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;
  assign last = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/unary_tape_writer.sv
// Writes the unary-addition tape (A^a ADD A^b BLANK) one cell per clock, all outputs registered.
// Define TAPE_WRITER_CLEAR_EN to blank the rest of the tape after the terminator.
module unary_tape_writer
  import tape_pkg::*;
#(
  parameter int unsigned TAPE_LEN = 64,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned OPW      = 5
) (
  input logic                 clk,
  input logic                 rst_n,
  unary_tape_writer_if.master bus
);
  localparam int unsigned CntW = ((OPW > ADDR_W) ? OPW : ADDR_W) + 1;
  localparam int unsigned SumW = OPW + 2;

  writer_state_e     state_q, state_d;
  logic [OPW-1:0]    op_b_q, op_b_d;
  logic              err_flag_q, err_flag_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [1:0]        wr_symb_q, wr_symb_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              emit_clr, emit_load, emit_step, emit_last;
  logic [CntW-1:0]   emit_val;
  logic [ADDR_W-1:0] emit_addr;
  logic [SumW-1:0]   sum;
  logic              ovf;

  assign sum = SumW'(bus.op_a) + SumW'(bus.op_b) + SumW'(2);
  assign ovf = 32'(sum) > TAPE_LEN;

`ifdef TAPE_WRITER_CLEAR_EN
  logic [CntW-1:0] rem;
  // Cells left after the terminator currently being written at emit_addr.
  assign rem = CntW'(TAPE_LEN - 1) - CntW'(emit_addr);
`endif

  unary_run_emit #(
    .CNT_W  (CntW),
    .ADDR_W (ADDR_W)
  ) u_emit (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (emit_clr),
    .load     (emit_load),
    .load_val (emit_val),
    .step     (emit_step),
    .addr     (emit_addr),
    .last     (emit_last)
  );

  always_comb begin
    state_d    = state_q;
    op_b_d     = op_b_q;
    err_flag_d = err_flag_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_symb_d  = SYMB_BLANK;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    emit_clr   = 1'b0;
    emit_load  = 1'b0;
    emit_val   = '0;
    emit_step  = 1'b0;

    // Every writing state emits one cell at the emitter address this cycle.
    if (state_q inside {StRunA, StSep, StRunB, StTerm, StClear}) begin
      wr_en_d   = 1'b1;
      wr_addr_d = emit_addr;
      busy_d    = 1'b1;
      emit_step = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          op_b_d    = bus.op_b;
          emit_clr  = 1'b1;
          emit_load = 1'b1;
          emit_val  = CntW'(bus.op_a);
          if (ovf) begin
            err_flag_d = 1'b1;
            state_d    = StFin;
          end else begin
            err_flag_d = 1'b0;
            state_d    = (bus.op_a == '0) ? StSep : StRunA;
          end
        end
      end
      StRunA: begin
        wr_symb_d = SYMB_A;
        if (emit_last) state_d = StSep;
      end
      StSep: begin
        wr_symb_d = SYMB_ADD;
        emit_load = 1'b1;
        emit_val  = CntW'(op_b_q);
        state_d   = (op_b_q == '0) ? StTerm : StRunB;
      end
      StRunB: begin
        wr_symb_d = SYMB_A;
        if (emit_last) state_d = StTerm;
      end
      StTerm: begin
        wr_symb_d = SYMB_BLANK;
`ifdef TAPE_WRITER_CLEAR_EN
        emit_load = 1'b1;
        emit_val  = rem;
        state_d   = (rem != '0) ? StClear : StFin;
`else
        state_d   = StFin;
`endif
      end
      StClear: begin
        wr_symb_d = SYMB_BLANK;
`ifdef TAPE_WRITER_CLEAR_EN
        if (emit_last) state_d = StFin;
`else
        state_d = StFin;
`endif
      end
      StFin: begin
        done_d  = 1'b1;
        err_d   = err_flag_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_b_q     <= '0;
      err_flag_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_symb_q  <= SYMB_BLANK;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_b_q     <= op_b_d;
      err_flag_q <= err_flag_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_symb_q  <= wr_symb_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_symb = wr_symb_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_unary_tape_writer.sv
// Directed bench for unary_tape_writer with a 16-cell tape model; honours TAPE_WRITER_CLEAR_EN.
module tb_unary_tape_writer;
  import tape_pkg::*;

  localparam int unsigned TapeLen = 16;
  localparam int unsigned AddrW   = 4;
  localparam int unsigned OpW     = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic preset_req = 1'b0;
  logic [1:0] tape [TapeLen];
  int n_assert = 0;
  int n_fail = 0;

  unary_tape_writer_if #(.ADDR_W(AddrW), .OPW(OpW)) bus ();

  unary_tape_writer #(
    .TAPE_LEN (TapeLen),
    .ADDR_W   (AddrW),
    .OPW      (OpW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Tape memory: stale pattern 11 on preset, otherwise commits writes.
  always @(posedge clk) begin
    if (preset_req) begin
      for (int i = 0; i < TapeLen; i++) tape[i] <= 2'b11;
    end else if (bus.wr_en) begin
      tape[bus.wr_addr] <= bus.wr_symb;
    end
  end

  function automatic logic [31:0] tape_flat();
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < TapeLen; i++) f[2*i +: 2] = tape[i];
    return f;
  endfunction

  function automatic logic [1:0] exp_sym(input int i, input int a, input int b);
    if (i < a) return SYMB_A;
    if (i == a) return SYMB_ADD;
    if (i <= a + b) return SYMB_A;
    return SYMB_BLANK;
  endfunction

  function automatic logic [31:0] stat();
    logic [AddrW-1:0] ad;
    ad = bus.wr_en ? bus.wr_addr : '0;
    return {22'b0, bus.wr_en, bus.busy, bus.done, bus.err, ad, bus.wr_symb};
  endfunction

  function automatic logic [31:0] exp_stat(input bit we, input bit bz, input bit dn, input bit er,
                                           input int addr, input logic [1:0] sy);
    logic [AddrW-1:0] ad;
    ad = AddrW'(addr);
    return {22'b0, we, bz, dn, er, ad, sy};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preset_tape();
    @(negedge clk) preset_req = 1'b1;
    @(negedge clk) preset_req = 1'b0;
  endtask

  task automatic run_case(input string tag, input int a, input int b, input bit inject);
    int w;
    bit ovf;
    logic [31:0] exp_tape;
    ovf = (a + b + 2 > TapeLen);
`ifdef TAPE_WRITER_CLEAR_EN
    w = ovf ? 0 : TapeLen;
`else
    w = ovf ? 0 : a + b + 2;
`endif
    preset_tape();
    bus.op_a  = OpW'(a);
    bus.op_b  = OpW'(b);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= w + 1; k++) begin
      @(negedge clk);
      if (k <= w)
        check($sformatf("%s_c%0d", tag, k), stat(), exp_stat(1, 1, 0, 0, k - 1, exp_sym(k - 1, a, b)));
      else
        check($sformatf("%s_done", tag), stat(), exp_stat(0, 0, 1, ovf, 0, SYMB_BLANK));
      if (inject && k == 2) begin
        bus.start = 1'b1;
        bus.op_a  = OpW'(1);
        bus.op_b  = OpW'(7);
      end
      if (inject && k == 3) bus.start = 1'b0;
    end
    @(negedge clk);
    check($sformatf("%s_idle", tag), stat(), exp_stat(0, 0, 0, 0, 0, SYMB_BLANK));
    exp_tape = '1;
    for (int i = 0; i < w; i++) exp_tape[2*i +: 2] = exp_sym(i, a, b);
    check($sformatf("%s_tape", tag), tape_flat(), exp_tape);
  endtask

  initial begin
    logic [31:0] exp_tape;
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    #12;
    check("reset_outs", stat(), exp_stat(0, 0, 0, 0, 0, SYMB_BLANK));
    check("reset_addr", 32'(bus.wr_addr), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    run_case("a3b2", 3, 2, 1'b0);
    run_case("a0b0", 0, 0, 1'b0);
    run_case("a9b5", 9, 5, 1'b0);
    run_case("a10b5", 10, 5, 1'b0);
    run_case("a0b4", 0, 4, 1'b0);
    run_case("a6b0", 6, 0, 1'b0);
    run_case("inject", 4, 3, 1'b1);

    // Reset during cycle 4 of an a=5 run.
    preset_tape();
    bus.op_a  = OpW'(5);
    bus.op_b  = OpW'(1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("rst_c%0d", k), stat(), exp_stat(1, 1, 0, 0, k - 1, SYMB_A));
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", stat(), exp_stat(0, 0, 0, 0, 0, SYMB_BLANK));
    check("rst_addr", 32'(bus.wr_addr), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rst_hold%0d", k), stat(), exp_stat(0, 0, 0, 0, 0, SYMB_BLANK));
    end
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("rst_post%0d", k), stat(), exp_stat(0, 0, 0, 0, 0, SYMB_BLANK));
    end
    exp_tape = '1;
    for (int i = 0; i < 3; i++) exp_tape[2*i +: 2] = SYMB_A;
    check("rst_partial_tape", tape_flat(), exp_tape);

    run_case("after_rst", 5, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
